// File: rtl/hough_pkg.sv
// Shared Hough-pipeline definitions: frame geometry defaults, edge threshold
// and the edge-reader state encoding.
package hough_pkg;

   localparam int unsigned DEFAULT_WIDTH          = 1280;
   localparam int unsigned DEFAULT_HEIGHT         = 720;
   localparam logic [7:0]  DEFAULT_EDGE_THRESHOLD = 8'd0;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } reader_state_t;

endpackage

// File: rtl/edge_pixel_reader_if.sv
// Edge-magnitude BRAM read port plus Hough input FIFO write port, as seen
// by the edge pixel reader (master) and the memory/FIFO side (slave).
interface edge_pixel_reader_if
   import hough_pkg::*;
#(
   parameter int unsigned WIDTH              = DEFAULT_WIDTH,
   parameter int unsigned HEIGHT             = DEFAULT_HEIGHT,
   parameter int unsigned REDUCED_IMAGE_SIZE = WIDTH * HEIGHT
);

   localparam int unsigned AW = $clog2(REDUCED_IMAGE_SIZE);
   localparam int unsigned XW = $clog2(WIDTH);
   localparam int unsigned YW = $clog2(HEIGHT);

   logic [AW-1:0] bram_rd_addr;
   logic [7:0]    bram_rd_data;
   logic          out_full;
   logic          out_wr_en;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;

   modport master (
      output bram_rd_addr,
      input  bram_rd_data,
      input  out_full,
      output out_wr_en,
      output out_x,
      output out_y
   );

   modport slave (
      input  bram_rd_addr,
      output bram_rd_data,
      output out_full,
      input  out_wr_en,
      input  out_x,
      input  out_y
   );

endinterface

// File: rtl/edge_pixel_reader.sv
// Raster-scans the edge-magnitude BRAM and pushes (x, y) of every pixel above
// threshold into the Hough FIFO, stalling on FIFO full without loss.
module edge_pixel_reader
   import hough_pkg::*;
#(
   parameter int unsigned WIDTH              = DEFAULT_WIDTH,
   parameter int unsigned HEIGHT             = DEFAULT_HEIGHT,
   parameter int unsigned REDUCED_IMAGE_SIZE = WIDTH * HEIGHT,
   parameter logic [7:0]  EDGE_THRESHOLD     = DEFAULT_EDGE_THRESHOLD
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    start,
   edge_pixel_reader_if.master                     bus,
   output logic                                    busy,
   output logic                                    done,
   output logic [$clog2(REDUCED_IMAGE_SIZE+1)-1:0] edge_count
);

   localparam int unsigned AW = $clog2(REDUCED_IMAGE_SIZE);
   localparam int unsigned XW = $clog2(WIDTH);
   localparam int unsigned YW = $clog2(HEIGHT);
   localparam int unsigned CW = $clog2(REDUCED_IMAGE_SIZE + 1);

   localparam logic [AW-1:0] LAST_ADDR = AW'(REDUCED_IMAGE_SIZE - 1);
   localparam logic [XW-1:0] LAST_COL  = XW'(WIDTH - 1);
   localparam logic [YW-1:0] LAST_ROW  = YW'(HEIGHT - 1);

   reader_state_t r_state, w_state_nxt;

   logic [AW-1:0] r_rd_cnt;
   logic [XW-1:0] r_col;
   logic [YW-1:0] r_row;
   logic          r_v1;
   logic [AW-1:0] r_a1;
   logic [XW-1:0] r_x1;
   logic [YW-1:0] r_y1;
   logic [CW-1:0] r_edge_count;

   logic w_hit;
   logic w_stall;

   assign w_hit   = r_v1 && (bus.bram_rd_data > EDGE_THRESHOLD);
   assign w_stall = w_hit && bus.out_full;

   // During a stall the pending address is re-issued so its data stays on the bus.
   assign bus.bram_rd_addr = ((r_state == SCAN) || (r_state == DRAIN))
                             ? (w_stall ? r_a1 : r_rd_cnt) : '0;
   assign bus.out_wr_en    = w_hit && !bus.out_full;
   assign bus.out_x        = r_x1;
   assign bus.out_y        = r_y1;
   assign busy             = (r_state != IDLE);
   assign done             = (r_state == DONE);
   assign edge_count       = r_edge_count;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:  if (start) w_state_nxt = SCAN;
         SCAN:  if (!w_stall && (r_rd_cnt == LAST_ADDR)) w_state_nxt = DRAIN;
         // The slot empties on this same edge, so DONE follows the last pixel directly.
         DRAIN: if (!w_stall) w_state_nxt = DONE;
         DONE:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_rd_cnt     <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_v1         <= 1'b0;
         r_a1         <= '0;
         r_x1         <= '0;
         r_y1         <= '0;
         r_edge_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (bus.out_wr_en) r_edge_count <= r_edge_count + CW'(1);

         case (r_state)
            IDLE: begin
               r_v1 <= 1'b0;
               if (start) begin
                  r_rd_cnt     <= '0;
                  r_col        <= '0;
                  r_row        <= '0;
                  r_edge_count <= '0;
               end
            end
            SCAN: begin
               if (!w_stall) begin
                  r_v1     <= 1'b1;
                  r_a1     <= r_rd_cnt;
                  r_x1     <= r_col;
                  r_y1     <= r_row;
                  r_rd_cnt <= r_rd_cnt + AW'(1);
                  if (r_col == LAST_COL) begin
                     r_col <= '0;
                     r_row <= (r_row == LAST_ROW) ? '0 : r_row + YW'(1);
                  end else begin
                     r_col <= r_col + XW'(1);
                  end
               end
            end
            DRAIN: if (!w_stall) r_v1 <= 1'b0;
            DONE:  r_v1 <= 1'b0;
            default: r_v1 <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_edge_pixel_reader.sv
// Directed bench for edge_pixel_reader on a 4x3 frame with a 1-cycle BRAM.
module tb_edge_pixel_reader;
   import hough_pkg::*;

   localparam int unsigned W   = 4;
   localparam int unsigned H   = 3;
   localparam int unsigned N   = W * H;
   localparam logic [7:0]  THR = 8'd0;

   typedef struct {
      logic [N*8-1:0] pix;
      int             full_from;
      int             full_to;
      int             restart_k;
      int             addr_k;
      int             exp_addr;
      int             exp_writes;
      int             exp_done;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       busy;
   logic       done;
   logic [3:0] edge_count;
   logic [7:0] mem [N];

   int n_vec = 0;
   int n_bad = 0;

   edge_pixel_reader_if #(.WIDTH(W), .HEIGHT(H), .REDUCED_IMAGE_SIZE(N)) bus ();

   edge_pixel_reader #(
      .WIDTH(W), .HEIGHT(H), .REDUCED_IMAGE_SIZE(N), .EDGE_THRESHOLD(THR)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .bus(bus.master),
      .busy(busy),
      .done(done),
      .edge_count(edge_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      bus.bram_rd_data <= (int'(bus.bram_rd_addr) < N) ? mem[bus.bram_rd_addr] : 8'd0;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s [vec %0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   function automatic logic [N*8-1:0] px(input int a, input logic [7:0] val);
      logic [N*8-1:0] p;
      p = '0;
      p[a*8 +: 8] = val;
      return p;
   endfunction

   task automatic load_mem(input logic [N*8-1:0] pix);
      for (int a = 0; a < int'(N); a++) mem[a] = pix[a*8 +: 8];
   endtask

   task automatic run_scan(input vec_t v, input int idx);
      int wr_k [16];
      int wr_x [16];
      int wr_y [16];
      int mk [16];
      int mx [16];
      int my [16];
      int nwr;
      int mn;
      int t;
      int done_k;
      int ndone;
      nwr = 0; mn = 0; t = 2; done_k = -1; ndone = 0;
      load_mem(v.pix);
      // Reference: strict raster order, each FIFO-full cycle on a hit delays by one.
      for (int a = 0; a < int'(N); a++) begin
         if (v.pix[a*8 +: 8] > THR) begin
            while (t >= v.full_from && t <= v.full_to) t++;
            mk[mn] = t; mx[mn] = a % W; my[mn] = a / W; mn++;
         end
         t++;
      end
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         bus.out_full = (k >= v.full_from && k <= v.full_to);
         start = (k == v.restart_k);
         @(negedge clock);
         if (k == v.addr_k) chk("rd_addr", idx, int'(bus.bram_rd_addr), v.exp_addr);
         if (bus.out_wr_en) begin
            if (nwr < 16) begin
               wr_k[nwr] = k; wr_x[nwr] = int'(bus.out_x); wr_y[nwr] = int'(bus.out_y);
            end
            nwr++;
         end
         if (done) begin
            if (done_k < 0) done_k = k;
            ndone++;
         end
         if (done_k >= 0 && k == done_k + 1) chk("busy_fall", idx, int'(busy), 0);
         if (done_k >= 0 && k == done_k + 3) break;
         @(posedge clock); #1;
      end
      start = 1'b0;
      bus.out_full = 1'b0;
      chk("done_cycle", idx, done_k, v.exp_done);
      chk("done_pulses", idx, ndone, 1);
      chk("write_count", idx, nwr, v.exp_writes);
      chk("edge_count", idx, int'(edge_count), v.exp_writes);
      for (int i = 0; i < mn && i < nwr && i < 16; i++) begin
         chk("wr_x", idx, wr_x[i], mx[i]);
         chk("wr_y", idx, wr_y[i], my[i]);
         chk("wr_cycle", idx, wr_k[i], mk[i]);
      end
   endtask

   vec_t vecs [9];
   logic [N*8-1:0] p3;

   initial begin
      int wr_seen;
      int done_seen;
      bus.out_full = 1'b0;
      for (int a = 0; a < int'(N); a++) mem[a] = 8'd0;
      p3 = px(0, 8'd10) | px(5, 8'd200) | px(11, 8'd1);

      //            pix                 f_from f_to rst addr_k addr writes done
      vecs[0] = '{'0,                   99,    0,   0,  1,     0,   0,     14};
      vecs[1] = '{p3,                   99,    0,   0,  12,    11,  3,     14};
      vecs[2] = '{px(5, 8'd200),        7,     10,  0,  9,     5,   1,     18};
      vecs[3] = '{{N{THR}},             99,    0,   0,  6,     5,   0,     14};
      vecs[4] = '{{N{THR + 8'd1}},      99,    0,   0,  12,    11,  12,    14};
      vecs[5] = '{p3,                   2,     3,   0,  3,     0,   3,     16};
      vecs[6] = '{px(5, 8'd200),        3,     6,   0,  5,     4,   1,     14};
      vecs[7] = '{px(11, 8'd200),       13,    14,  0,  14,    11,  1,     16};
      vecs[8] = '{p3,                   99,    0,   5,  5,     4,   3,     14};

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_wr_en", -1, int'(bus.out_wr_en), 0);
      chk("rst_done", -1, int'(done), 0);
      chk("rst_busy", -1, int'(busy), 0);
      chk("rst_addr", -1, int'(bus.bram_rd_addr), 0);
      chk("rst_x", -1, int'(bus.out_x), 0);
      chk("rst_y", -1, int'(bus.out_y), 0);
      chk("rst_edge_count", -1, int'(edge_count), 0);
      reset = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < 9; i++) run_scan(vecs[i], i);

      // Reset mid-scan: asserted during cycle E+6, everything clear in E+7.
      load_mem(p3);
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      repeat (5) begin
         @(posedge clock); #1;
      end
      reset = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      chk("mid_rst_wr_en", 100, int'(bus.out_wr_en), 0);
      chk("mid_rst_done", 100, int'(done), 0);
      chk("mid_rst_busy", 100, int'(busy), 0);
      chk("mid_rst_addr", 100, int'(bus.bram_rd_addr), 0);
      chk("mid_rst_x", 100, int'(bus.out_x), 0);
      chk("mid_rst_y", 100, int'(bus.out_y), 0);
      chk("mid_rst_edge_count", 100, int'(edge_count), 0);
      reset = 1'b1;
      wr_seen = 0;
      done_seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (bus.out_wr_en) wr_seen++;
         if (done) done_seen++;
      end
      chk("post_rst_writes", 100, wr_seen, 0);
      chk("post_rst_done", 100, done_seen, 0);
      run_scan(vecs[1], 101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/edge_pixel_reader.md
# edge_pixel_reader

- Scans the edge-magnitude BRAM written by the hysteresis stage and emits the (x, y) coordinates of every surviving edge pixel into the Hough input FIFO.
- Starts on the hysteresis stage's `hough_start` pulse and reads the frame in raster order, one BRAM read per cycle.
- Obeys FIFO backpressure without losing or duplicating pixels, then pulses `done` with the edge count.

## Interface
- `WIDTH`, 1280: image width in pixels.
- `HEIGHT`, 720: image height in pixels.
- `REDUCED_IMAGE_SIZE`, `WIDTH*HEIGHT`: BRAM depth; last address is `REDUCED_IMAGE_SIZE-1`.
- `EDGE_THRESHOLD`, 0: a pixel is an edge iff its value > `EDGE_THRESHOLD` (unsigned 8-bit compare).
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: one-cycle start pulse, driven by the hysteresis stage's `hough_start`.
- `bram_rd_addr` out `$clog2(REDUCED_IMAGE_SIZE)`: read address. It is combinational, and the BRAM is read with 1-cycle latency.
- `bram_rd_data` in 8: pixel value for the address presented in the previous cycle.
- `out_full` in 1: the output FIFO is full.
- `out_wr_en` out 1: output FIFO write strobe. It is combinational.
- `out_x` out `$clog2(WIDTH)`: column of the emitted pixel.
- `out_y` out `$clog2(HEIGHT)`: row of the emitted pixel.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when the scan completes.
- `edge_count` out `$clog2(REDUCED_IMAGE_SIZE+1)`: number of pixels emitted in the current or last scan. It is cleared on `start` and held after `done`.

## Operation
- States and transitions:
  - IDLE → SCAN when `start` is high.
  - SCAN → DRAIN after address `REDUCED_IMAGE_SIZE-1` is issued.
  - DRAIN → DONE when the pipeline slot is empty.
  - DONE → IDLE unconditionally.
- `start` is ignored outside IDLE.
- Registers:
  - `rd_cnt`: next address to issue.
  - Pipeline slot `v1`/`a1`/`x1`/`y1`: valid bit, address and coordinates of the read whose data is on `bram_rd_data` this cycle.
  - `x1`/`y1` are maintained as col/row counters, not by division. Col wraps `WIDTH-1` → 0 with row+1.
- `hit = v1 && bram_rd_data > EDGE_THRESHOLD`; `stall = hit && out_full`.
- `out_wr_en = hit && !out_full`; `out_x = x1`; `out_y = y1`.
  - `edge_count` increments on each write.
  - Zero or sub-threshold pixels are dropped silently.
- `bram_rd_addr = stall ? a1 : rd_cnt`.
  - The pending address is re-read so its data remains valid next cycle.
  - Slot, `rd_cnt` and coordinates hold while stalled.
- In SCAN, when not stalled, the slot loads `rd_cnt` (`v1 ← 1`) and `rd_cnt` increments.
  - The transition to DRAIN happens on the edge that issues `REDUCED_IMAGE_SIZE-1`.
- In DRAIN, when not stalled, `v1 ← 0`.
- In IDLE and DONE: `bram_rd_addr = 0`, `v1 = 0`, `out_wr_en = 0`.
- In DONE: `done = 1` for exactly one cycle.
- Reset value of every output:
  - `out_wr_en`, `done`, `busy`, `bram_rd_addr`, `out_x`, `out_y` and `edge_count` are all 0.
  - State is IDLE.
- Reset asserted mid-scan: everything returns to reset values on that edge. No further writes, and no `done`.

## Timing
- `start` is sampled high at edge E.
  - Address 0 is presented in cycle E+1.
  - Pixel 0 can be written at the earliest in cycle E+2.
- No backpressure: one pixel is evaluated per cycle.
  - Last pixel evaluated in cycle E+`REDUCED_IMAGE_SIZE`+1.
  - `done` in cycle E+`REDUCED_IMAGE_SIZE`+2.
  - `busy` falls the cycle after that.
- Each cycle of `stall` adds exactly one cycle. Ordering is strict raster order.
- `out_full` rising while the pending pixel is zero has no effect: no write is needed, so there is no stall.
- `out_full` and `hit` high together means the write is withheld. The write occurs in the first cycle with `out_full` low, with the same `out_x`/`out_y`.

## Structure
- Shared `hough_pkg` holds:
  - `WIDTH`/`HEIGHT` defaults.
  - The `reader_state_t` enum {IDLE, SCAN, DRAIN, DONE}.
  - `EDGE_THRESHOLD` default, shared with the Hough accumulator.
- Single module; no sub-module. The counters and the slot are too small to justify splitting.

## Test plan
Bench setup for all scenarios: `WIDTH`=4, `HEIGHT`=3, behavioral BRAM with 1-cycle latency.
- All-zero BRAM, `start` pulse → no `out_wr_en`; `done` at E+14; `edge_count`=0.
- Nonzero pixels at addresses 0, 5 and 11, `out_full`=0 → exactly three writes at (0,0), (1,1), (3,2) in cycles E+2, E+7, E+13; `edge_count`=3.
- Address 5=200, `out_full` held high for cycles E+7..E+10 → a single write (1,1) in cycle E+11; `bram_rd_addr`=5 during the stall; `done` delayed by 4 cycles; no duplicate.
- All pixels = `EDGE_THRESHOLD`, then all = `EDGE_THRESHOLD`+1 → 0 writes, then 12 writes in raster order with `edge_count`=12.
- `reset` low at E+6 mid-scan → next cycle all outputs are 0 and the state is IDLE; no `done`; a following `start` rescans from (0,0).
- Second `start` pulse while `busy` → ignored; exactly one `done`; `edge_count` is unchanged by the ignored pulse.
